auth_core: RTL and testbench
============================

# auth_core

Key-entry authentication engine instantiated by `top`, downstream of the TinyTapeout pin wrapper. It accepts key bytes one per qualified strobe and compares them in-flight against a fixed key. It issues a timed grant on match and a fail pulse on mismatch. After repeated failures it enters a timed lockout. Entered bytes are never stored; only a running mismatch flag is kept.

## Interface
- `KEY_BYTES`, 4: key length in bytes.
- `KEY`, 32'hA5C3_5A3C: reference key, width 8*KEY_BYTES, most significant byte entered first.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout; must be ≥1.
- `LOCK_CYCLES`, 1024: lockout duration in clocks; must be ≥1.
- `GRANT_CYCLES`, 16: grant pulse width in clocks; must be ≥1.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in 8: key byte, sampled only when `data_valid`=1.
- `data_valid` in 1: single-cycle byte strobe (already edge-qualified upstream).
- `clear` in 1: abort partial entry.
- `grant` out 1: access granted, high GRANT_CYCLES cycles.
- `fail` out 1: one-cycle pulse per rejected key.
- `locked` out 1: lockout active.
- `busy` out 1: state ≠ IDLE.
- `fail_count` out $clog2(MAX_FAILS+1): consecutive failures so far.

## Operation
- States: IDLE, ENTRY, CHECK, GRANT, FAIL, LOCK.
- All outputs register 0 under `rst`, and state returns to IDLE. `rst` overrides everything, including mid-lockout and mid-grant.
- IDLE/ENTRY, `data_valid`=1: compare `data_in` against KEY byte[idx] and OR any mismatch into `mis`, then increment `idx`.
  - The first byte moves IDLE→ENTRY, with `idx`=0 and `mis` cleared.
  - Accepting byte KEY_BYTES-1 moves to CHECK.
- ENTRY, `clear`=1: go to IDLE and discard `idx`/`mis`. No failure is counted. `clear` beats `data_valid` in the same cycle. `clear` is ignored in every other state.
- CHECK, one cycle:
  - `mis`=0: go to GRANT and zero `fail_count`.
  - `mis`=1: increment `fail_count`. If the new count equals MAX_FAILS, go to LOCK; otherwise go to FAIL.
- GRANT: hold for GRANT_CYCLES cycles, then go to IDLE.
- FAIL: lasts one cycle, then go to IDLE.
- LOCK:
  - Load the timer with LOCK_CYCLES and count down. At terminal count, zero `fail_count` and go to IDLE.
  - `fail` is also pulsed on lock entry.
- `data_valid` is ignored in CHECK, GRANT, FAIL and LOCK. Bytes arriving there are dropped, not queued.
- `fail_count` saturates at MAX_FAILS. It does not wrap.

## Timing
- Last byte strobed at cycle t: CHECK at t+1. `grant`, or `fail` (plus `locked` if lockout), is high from t+2.
- `grant` is high for exactly GRANT_CYCLES cycles, t+2 … t+1+GRANT_CYCLES. The next byte is accepted at t+2+GRANT_CYCLES.
- `fail` is high for exactly 1 cycle (t+2). The next byte is accepted at t+3.
- `locked` is high for exactly LOCK_CYCLES cycles starting t+2. `fail_count` reads 0 on the first cycle after `locked` falls.
- Response latency is the same for match and mismatch, and does not depend on which byte mismatched (no timing side channel).
- `busy` is registered and asserted from the cycle after the first accepted byte.

## Structure
- Package `auth_pkg`:
  - state encoding constants;
  - default KEY, MAX_FAILS, LOCK_CYCLES and GRANT_CYCLES values;
  - a function returning KEY byte[idx].
- Sub-module `auth_timer`: a loadable down-counter with `load`, `value` and a `done` pulse. It is shared by GRANT and LOCK; its width comes from the maximum of the two durations.
- The FSM, `idx`/`mis` and `fail_count` live in `auth_core`.

## Test plan
- Send A5,C3,5A,3C on consecutive strobes → `grant`=1 from cycle t+2 for 16 cycles; `fail`=0; `fail_count`=0.
- Send A5,C3,5A,3D → `fail` is a 1-cycle pulse at t+2; `fail_count`=1; `grant` stays 0.
- Send three wrong keys → third yields `fail` and `locked`=1 for 1024 cycles. A correct key sent during lockout gives no `grant`. After unlock `fail_count`=0 and a correct key grants.
- Send A5,C3 then `clear`, then the full correct key → `grant` asserted; `fail_count` unchanged at 0.
- `clear` and `data_valid` in the same ENTRY cycle → entry discarded, IDLE next, byte not counted.
- `rst` pulse at lock cycle 500 → all outputs 0 the next cycle, `fail_count`=0, correct key grants immediately after.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared definitions for the key-entry authentication engine: state encoding,
// default key/timing values and the key byte selector.
package auth_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_GRANT = 3'd3,
    S_FAIL  = 3'd4,
    S_LOCK  = 3'd5
  } auth_state_e;

  localparam int          DEFAULT_KEY_BYTES    = 4;
  localparam logic [31:0] DEFAULT_KEY          = 32'hA5C3_5A3C;
  localparam int          DEFAULT_MAX_FAILS    = 3;
  localparam int          DEFAULT_LOCK_CYCLES  = 1024;
  localparam int          DEFAULT_GRANT_CYCLES = 16;

  // Keys up to this length can be passed through key_byte().
  localparam int KEY_MAX_BYTES = 32;
  localparam int KEY_MAX_BITS  = 8 * KEY_MAX_BYTES;

  // Byte idx of an nbytes-long key; byte 0 is the most significant one.
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_BITS-1:0] key,
                                          input int nbytes, input int idx);
    logic [KEY_MAX_BITS-1:0] shifted;
    shifted = key >> (8 * (nbytes - 1 - idx));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/auth_timer.sv
// Loadable down-counter shared by the grant and lockout phases; done is high
// on the last cycle of the loaded duration.
module auth_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/auth_core.sv
// Key-entry authentication FSM: compares bytes in flight, grants on match,
// pulses fail on mismatch and locks out after repeated failures.
module auth_core
  import auth_pkg::*;
#(
  parameter int                     KEY_BYTES    = DEFAULT_KEY_BYTES,
  parameter logic [8*KEY_BYTES-1:0] KEY          = DEFAULT_KEY,
  parameter int                     MAX_FAILS    = DEFAULT_MAX_FAILS,
  parameter int                     LOCK_CYCLES  = DEFAULT_LOCK_CYCLES,
  parameter int                     GRANT_CYCLES = DEFAULT_GRANT_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         data_in,
  input  logic                               data_valid,
  input  logic                               clear,
  output logic                               grant,
  output logic                               fail,
  output logic                               locked,
  output logic                               busy,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int FC_W      = $clog2(MAX_FAILS + 1);
  localparam int TIMER_MAX = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(KEY_BYTES - 1);
  localparam logic [FC_W-1:0]         FC_MAX     = FC_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0]      GRANT_LOAD = TIMER_W'(GRANT_CYCLES);
  localparam logic [TIMER_W-1:0]      LOCK_LOAD  = TIMER_W'(LOCK_CYCLES);
  localparam logic [KEY_MAX_BITS-1:0] KEY_EXT    = KEY_MAX_BITS'(KEY);

  auth_state_e      state, state_next;
  logic [IDX_W-1:0] idx, idx_next, cur_idx;
  logic             mis, mis_next, byte_mis;
  logic [FC_W-1:0]  fc_next, fc_inc;
  logic             fail_next, accept;
  logic             timer_load, timer_done;
  logic [TIMER_W-1:0] timer_value;

  // data_valid is a one-cycle strobe with no back-pressure: a byte is taken in
  // IDLE/ENTRY when clear is not winning that cycle, and dropped anywhere else.
  assign cur_idx  = (state == S_IDLE) ? '0 : idx;
  assign byte_mis = (data_in != key_byte(KEY_EXT, KEY_BYTES, int'(cur_idx)));
  assign accept   = data_valid && ((state == S_IDLE) || (state == S_ENTRY && !clear));
  assign fc_inc   = (fail_count == FC_MAX) ? fail_count : fail_count + FC_W'(1);

  auth_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      mis        <= 1'b0;
      fail_count <= '0;
      grant      <= 1'b0;
      fail       <= 1'b0;
      locked     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      mis        <= mis_next;
      fail_count <= fc_next;
      grant      <= (state_next == S_GRANT);
      fail       <= fail_next;
      locked     <= (state_next == S_LOCK);
      busy       <= (state_next != S_IDLE);
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    mis_next    = mis;
    fc_next     = fail_count;
    fail_next   = 1'b0;
    timer_load  = 1'b0;
    timer_value = GRANT_LOAD;

    case (state)
      S_IDLE, S_ENTRY: begin
        if (state == S_ENTRY && clear) begin
          state_next = S_IDLE;
          idx_next   = '0;
          mis_next   = 1'b0;
        end else if (accept) begin
          // Mismatch is only accumulated, so every key takes the same time.
          idx_next   = cur_idx + IDX_W'(1);
          mis_next   = (state == S_IDLE) ? byte_mis : (mis | byte_mis);
          state_next = (cur_idx == LAST_IDX) ? S_CHECK : S_ENTRY;
        end
      end
      S_CHECK: begin
        idx_next   = '0;
        timer_load = 1'b1;
        if (!mis) begin
          fc_next    = '0;
          state_next = S_GRANT;
        end else begin
          fc_next   = fc_inc;
          fail_next = 1'b1;
          if (fc_inc == FC_MAX) begin
            state_next  = S_LOCK;
            timer_value = LOCK_LOAD;
          end else begin
            state_next = S_FAIL;
          end
        end
      end
      S_GRANT: begin
        if (timer_done) state_next = S_IDLE;
      end
      S_FAIL: begin
        state_next = S_IDLE;
      end
      S_LOCK: begin
        if (timer_done) begin
          fc_next    = '0;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_auth_core.sv
// Directed bench for auth_core: expected outcomes per key are queued when the key
// is sent and popped when grant rises or fail pulses; timing is checked inline.
module tb_auth_core;

  localparam logic [31:0] KEY = 32'hA5C3_5A3C;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       clear;
  logic       grant;
  logic       fail;
  logic       locked;
  logic       busy;
  logic [1:0] fail_count;

  int errors = 0;
  int checks = 0;
  int mfc    = 0;
  logic [2:0] exp_q[$];
  logic       grant_d;

  auth_core dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear      (clear),
    .grant      (grant),
    .fail       (fail),
    .locked     (locked),
    .busy       (busy),
    .fail_count (fail_count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drivers: called on a negedge, returns on the negedge of the CHECK cycle.
  task automatic send_key(input logic [31:0] k);
    for (int i = 0; i < 4; i++) begin
      data_in    = k[31-8*i -: 8];
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  // Outcome codes are {grant, fail, locked} on the first cycle of the response.
  task automatic send_key_exp(input logic [31:0] k);
    logic [2:0] code;
    if (k == KEY) begin
      code = 3'b100;
      mfc  = 0;
    end else begin
      mfc++;
      if (mfc == 3) begin
        code = 3'b011;
        mfc  = 0;
      end else begin
        code = 3'b010;
      end
    end
    exp_q.push_back(code);
    send_key(k);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fail_count"}, fail_count, 0);
  endtask

  // Scoreboard: every response start must match the oldest queued outcome.
  always @(negedge clk) begin
    if (rst) begin
      grant_d <= 1'b0;
    end else begin
      if ((grant && !grant_d) || fail) begin
        logic [2:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        chk("outcome", {29'd0, grant, fail, locked}, {29'd0, e});
      end
      grant_d <= grant;
    end
  end

  initial begin
    int n;
    logic grant_seen;
    logic [31:0] kv;

    rst = 1'b1; data_valid = 1'b0; clear = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Correct key
    send_key_exp(KEY);
    chk("check_busy", busy, 1);
    chk("check_no_grant", grant, 0);
    @(negedge clk);
    chk("grant_t2", grant, 1);
    chk("grant_no_fail", fail, 0);
    chk("grant_fc", fail_count, 0);
    n = 0;
    while (grant && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("grant_width", n, 16);
    chk("idle_after_grant", busy, 0);

    // Wrong last byte
    send_key_exp(32'hA5C3_5A3D);
    @(negedge clk);
    chk("fail_t2", fail, 1);
    chk("fail_no_grant", grant, 0);
    chk("fail_fc1", fail_count, 1);
    chk("fail_not_locked", locked, 0);
    @(negedge clk);
    chk("fail_width", fail, 0);
    chk("fail_idle", busy, 0);

    // Wrong first byte: same latency
    send_key_exp(32'h00C3_5A3C);
    @(negedge clk);
    chk("fail_first_byte_t2", fail, 1);
    chk("fail_fc2", fail_count, 2);
    wait_idle();

    // Third failure locks; a correct key during lockout is dropped
    send_key_exp(32'hA5C3_FF3C);
    @(negedge clk);
    chk("lock_fail", fail, 1);
    chk("lock_locked", locked, 1);
    chk("lock_fc3", fail_count, 3);
    kv = KEY;
    grant_seen = 1'b0;
    n = 0;
    while (locked && n < 2000) begin
      if (n >= 10 && n < 14) begin
        data_valid = 1'b1;
        data_in    = kv[31-8*(n-10) -: 8];
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
      grant_seen = grant_seen | grant;
      n++;
    end
    data_valid = 1'b0;
    chk("lock_width", n, 1024);
    chk("lock_no_grant", grant_seen, 0);
    chk("unlock_fc0", fail_count, 0);
    chk("unlock_idle", busy, 0);

    send_key_exp(KEY);
    @(negedge clk);
    chk("unlock_grant", grant, 1);
    wait_idle();

    // Partial entry aborted by clear does not count as a failure
    send_key_exp(32'h1111_1111);
    wait_idle();
    chk("pre_clear_fc", fail_count, 1);
    data_valid = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    data_in = 8'hC3;
    @(negedge clk);
    data_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_idle", busy, 0);
    chk("clear_no_fail", fail, 0);
    chk("clear_fc", fail_count, 1);
    send_key_exp(KEY);
    @(negedge clk);
    chk("clear_then_grant", grant, 1);
    chk("clear_then_fc", fail_count, 0);
    wait_idle();

    // clear beats data_valid in the same ENTRY cycle
    data_valid = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    data_in = 8'hC3; clear = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; clear = 1'b0;
    chk("clear_dv_idle", busy, 0);
    send_key_exp(KEY);
    chk("clear_dv_check", busy, 1);
    @(negedge clk);
    chk("clear_dv_grant", grant, 1);
    wait_idle();

    // Reset in the middle of a lockout
    send_key_exp(32'h0000_0000);
    wait_idle();
    send_key_exp(32'hFFFF_FFFF);
    wait_idle();
    send_key_exp(32'hA5C3_5A00);
    @(negedge clk);
    chk("lock2_locked", locked, 1);
    repeat (500) @(negedge clk);
    chk("lock2_still_locked", locked, 1);
    rst = 1'b1;
    mfc = 0;
    @(negedge clk);
    chk_all_zero("mid_lock_reset");
    rst = 1'b0;
    send_key_exp(KEY);
    @(negedge clk);
    chk("post_reset_grant", grant, 1);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
